// File: rtl/uart_packet_tx_if.sv
// Producer-side handshake for uart_packet_tx: byte stream in, buffer status out.
// The transmitter takes the slave modport and the producer drives the master side.
interface uart_packet_tx_if #(
  parameter int DEPTH = 32
);
  logic [7:0]              byte_in;
  logic                    byte_valid;
  logic                    packet_end;
  logic                    byte_ready;
  logic [$clog2(DEPTH):0]  byte_count;
  logic                    overflow;

  modport master (
    output byte_in, byte_valid, packet_end,
    input  byte_ready, byte_count, overflow
  );

  modport slave (
    input  byte_in, byte_valid, packet_end,
    output byte_ready, byte_count, overflow
  );
endinterface

// File: rtl/uart_packet_tx.sv
// Packet-framed 8N1 UART transmitter: buffers a packet, sends it back-to-back, then holds a quiet gap.
// Define UART_PKT_CHECKSUM_EN to append a frame that brings the byte sum of each packet to zero.
module uart_packet_tx #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DEPTH           = 32,
  parameter int GAP_BYTES       = 2
) (
  input  logic             clock,
  input  logic             reset,
  uart_packet_tx_if.slave  prod,
  output logic             uart_tx_pin,
  output logic             busy,
  output logic             packet_sent
);
  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int GAP_CLOCKS   = GAP_BYTES * 10 * BAUD_DIVISOR;
  localparam int AW           = $clog2(DEPTH);
  localparam int CW           = AW + 1;
  localparam int TW           = $clog2(GAP_CLOCKS);

  typedef enum logic [1:0] {LOAD, SEND, GAP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   frame_reg;
  logic [3:0]      bit_reg;
  logic [TW-1:0]   timer_reg;
  logic            tx_reg, tx_next;
  logic            overflow_reg;
  logic            packet_sent_reg;
  logic [7:0]      rd_data_reg;
  logic [7:0]      mem [DEPTH];

  logic            ready, accept, commit, bit_end, frame_end, last_frame, gap_done;
  logic [CW-1:0]   count_after;
  logic [7:0]      frame_byte;
  logic [2:0]      data_idx;

  assign ready       = (state_reg == LOAD) && (count_reg != CW'(DEPTH));
  assign accept      = prod.byte_valid && ready;
  assign count_after = count_reg + {{(CW-1){1'b0}}, accept};
  assign commit      = (state_reg == LOAD) && prod.packet_end && (count_after != '0);
  assign bit_end     = (state_reg == SEND) && (timer_reg == TW'(BAUD_DIVISOR - 1));
  assign frame_end   = bit_end && (bit_reg == 4'd9);
  // The pin register adds one edge of lag, so the line stays high one cycle beyond the
  // GAP state; the idle time seen on the wire before the next start bit still covers the gap.
  assign gap_done    = (state_reg == GAP) && (timer_reg == TW'(GAP_CLOCKS - 1));
  assign data_idx    = 3'(bit_reg - 4'd1);

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic       checksum_frame;

  // The frame after the last buffered byte carries the two's-complement of the running sum.
  assign checksum_frame = (frame_reg == count_reg);
  assign last_frame     = checksum_frame;
  assign frame_byte     = checksum_frame ? (8'd0 - sum_reg) : rd_data_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_reg <= 8'd0;
    end else if (gap_done) begin
      sum_reg <= 8'd0;
    end else if (accept) begin
      sum_reg <= sum_reg + prod.byte_in;
    end
  end
`else
  assign last_frame = ((frame_reg + CW'(1)) == count_reg);
  assign frame_byte = rd_data_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (commit) state_next = SEND;
      SEND:    if (frame_end && last_frame) state_next = GAP;
      GAP:     if (gap_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    if (state_reg == SEND) begin
      if (bit_reg == 4'd0)      tx_next = 1'b0;
      else if (bit_reg == 4'd9) tx_next = 1'b1;
      else                      tx_next = frame_byte[data_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_reg          <= 1'b1;
      overflow_reg    <= 1'b0;
      packet_sent_reg <= 1'b0;
      count_reg       <= '0;
      frame_reg       <= '0;
      bit_reg         <= 4'd0;
      timer_reg       <= '0;
    end else begin
      tx_reg          <= tx_next;
      overflow_reg    <= prod.byte_valid && !ready;
      packet_sent_reg <= gap_done;
      if (accept) count_reg <= count_reg + CW'(1);
      case (state_reg)
        SEND: begin
          if (bit_end) begin
            timer_reg <= '0;
            if (bit_reg == 4'd9) begin
              bit_reg   <= 4'd0;
              frame_reg <= frame_reg + CW'(1);
            end else begin
              bit_reg <= bit_reg + 4'd1;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        GAP: begin
          if (gap_done) begin
            timer_reg <= '0;
            count_reg <= '0;
            frame_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          timer_reg <= '0;
          bit_reg   <= 4'd0;
          frame_reg <= '0;
        end
      endcase
    end
  end

  // Write address is the fill level and read address is the frame index, so both wrap with DEPTH.
  always_ff @(posedge clock) begin
    if (accept) mem[count_reg[AW-1:0]] <= prod.byte_in;
    rd_data_reg <= mem[frame_reg[AW-1:0]];
  end

  assign prod.byte_ready = ready;
  assign prod.byte_count = count_reg;
  assign prod.overflow   = overflow_reg;
  assign uart_tx_pin     = tx_reg;
  assign busy            = (state_reg != LOAD);
  assign packet_sent     = packet_sent_reg;
endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: random packets compared against a frame-level model of the line.
// Define UART_PKT_CHECKSUM_EN here too when the design is built with the checksum frame.
module tb_uart_packet_tx;
  localparam int CLOCK_FREQUENCY = 1000000;
  localparam int BAUD_RATE       = 100000;
  localparam int DEPTH           = 32;
  localparam int GAP_BYTES       = 2;
  localparam int BD              = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int FRAME_CLKS      = 10 * BD;
  localparam int GAP_CLKS        = GAP_BYTES * FRAME_CLKS;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_tx_pin, busy, packet_sent;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sum_model = 8'd0;

  uart_packet_tx_if #(.DEPTH(DEPTH)) bus ();

  uart_packet_tx #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .BAUD_RATE(BAUD_RATE),
    .DEPTH(DEPTH),
    .GAP_BYTES(GAP_BYTES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .prod(bus),
    .uart_tx_pin(uart_tx_pin),
    .busy(busy),
    .packet_sent(packet_sent)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Ideal 8N1 line waveform of one frame, one entry per clock, earliest clock at index 0.
  function automatic logic [FRAME_CLKS-1:0] frame_wave(input logic [7:0] b);
    logic [FRAME_CLKS-1:0] w;
    logic bitv;
    w = '0;
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      bitv = 1'b0;
      else if (j == 9) bitv = 1'b1;
      else             bitv = b[j-1];
      for (int c = 0; c < BD; c++) w[j*BD + c] = bitv;
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit last);
    bit acc;
    acc = (exp_q.size() < DEPTH);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.packet_end = last;
    @(posedge clock); #1;
    bus.byte_valid = 1'b0;
    bus.packet_end = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
      sum_model = sum_model + b;
    end
    check("overflow", bus.overflow, !acc);
    check("byte_count", bus.byte_count, exp_q.size());
  endtask

  task automatic commit_only();
    bus.packet_end = 1'b1;
    @(posedge clock); #1;
    bus.packet_end = 1'b0;
  endtask

  // Called one sample after the commit edge; t counts clocks from that edge.
  task automatic expect_packet(input int inject_t);
    logic [7:0] frames[$];
    logic [FRAME_CLKS-1:0] obs_v;
    int nf, t_ps, t_end, fi, pos;
    int gap_low, busy_hi, ps_first, ps_cnt, ovf_cnt;
    logic ready_at_ps, busy_at_ps;
    logic [7:0] count_at_ps;
    frames = exp_q;
`ifdef UART_PKT_CHECKSUM_EN
    frames.push_back(8'd0 - sum_model);
`endif
    nf = frames.size();
    t_ps = nf * FRAME_CLKS + GAP_CLKS;
    t_end = t_ps + 4;
    obs_v = '0;
    gap_low = 0; busy_hi = 0; ps_first = -1; ps_cnt = 0; ovf_cnt = 0;
    ready_at_ps = 1'b0; busy_at_ps = 1'b1; count_at_ps = 8'hFF;
    for (int t = 1; t <= t_end; t++) begin
      @(posedge clock); #1;
      if (t <= nf * FRAME_CLKS) begin
        fi = (t - 1) / FRAME_CLKS;
        pos = (t - 1) % FRAME_CLKS;
        obs_v[pos] = uart_tx_pin;
        if (pos == FRAME_CLKS - 1)
          check($sformatf("frame%0d_of_%0d", fi, nf), obs_v, frame_wave(frames[fi]));
      end else if (uart_tx_pin !== 1'b1) begin
        gap_low++;
      end
      if (t < t_ps && busy === 1'b1) busy_hi++;
      if (packet_sent === 1'b1) begin
        ps_cnt++;
        if (ps_first < 0) ps_first = t;
      end
      if (t == t_ps) begin
        ready_at_ps = bus.byte_ready;
        busy_at_ps  = busy;
        count_at_ps = 8'(bus.byte_count);
      end
      if (bus.overflow === 1'b1) ovf_cnt++;
      bus.byte_valid = (t == inject_t);
      if (t == inject_t) bus.byte_in = 8'($urandom);
    end
    check("gap_pin_high", gap_low, 0);
    check("busy_during_packet", busy_hi, t_ps - 1);
    check("packet_sent_time", ps_first, t_ps);
    check("packet_sent_pulses", ps_cnt, 1);
    check("ready_at_sent", ready_at_ps, 1'b1);
    check("busy_at_sent", busy_at_ps, 1'b0);
    check("count_at_sent", count_at_ps, 8'd0);
    check("overflow_in_send", ovf_cnt, (inject_t > 0) ? 1 : 0);
    exp_q.delete();
    sum_model = 8'd0;
  endtask

  initial begin
    int n, anomalies, ps_cnt, low_cnt;
    bit end_same;
    bus.byte_in = 8'd0;
    bus.byte_valid = 1'b0;
    bus.packet_end = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_pin", uart_tx_pin, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", bus.byte_ready, 1'b1);
    check("reset_count", bus.byte_count, 0);
    check("reset_overflow", bus.overflow, 1'b0);
    check("reset_sent", packet_sent, 1'b0);
    reset = 1'b0;
    idle(1);

    // Single byte committed on the same cycle.
    push_byte(8'hA5, 1'b1);
    expect_packet(0);

    // Three bytes, commit on a separate cycle.
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b0);
    commit_only();
    expect_packet(0);

    // Random packets with random spacing and commit style.
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 8);
      end_same = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 3));
        push_byte(8'($urandom), end_same && (i == n - 1));
      end
      if (!end_same) commit_only();
      expect_packet(0);
    end

    // Two-byte packet whose checksum frame would be 0xD0.
    push_byte(8'h10, 1'b0);
    push_byte(8'h20, 1'b1);
    expect_packet(0);

    // Fill the buffer, overflow once, then commit together with a dropped byte.
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 1'b0);
    check("full_ready", bus.byte_ready, 1'b0);
    push_byte(8'($urandom), 1'b0);
    idle(1);
    check("overflow_single_pulse", bus.overflow, 1'b0);
    check("full_count_held", bus.byte_count, DEPTH);
    push_byte(8'($urandom), 1'b1);
    expect_packet(0);

    // Commit with an empty buffer is ignored.
    commit_only();
    anomalies = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b0 || uart_tx_pin !== 1'b1 || packet_sent !== 1'b0 || bus.byte_ready !== 1'b1)
        anomalies++;
      idle(1);
    end
    check("empty_commit_ignored", anomalies, 0);

    // A byte offered mid-packet is dropped and flagged.
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), i == 2);
    expect_packet($urandom_range(2, 3 * FRAME_CLKS - 2));

    // Reset during bit 4 of the second frame.
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), i == 2);
    idle(FRAME_CLKS + 4 * BD + 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    exp_q.delete();
    sum_model = 8'd0;
    check("midreset_pin", uart_tx_pin, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_count", bus.byte_count, 0);
    check("midreset_ready", bus.byte_ready, 1'b1);
    ps_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (packet_sent === 1'b1) ps_cnt++;
      if (uart_tx_pin !== 1'b1 || busy !== 1'b0) low_cnt++;
      idle(1);
    end
    check("midreset_no_sent", ps_cnt, 0);
    check("midreset_line_idle", low_cnt, 0);

    // Fresh packet after the reset.
    push_byte(8'($urandom), 1'b0);
    push_byte(8'($urandom), 1'b1);
    expect_packet(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
Packet-framed UART transmitter, the sending end of our quiet-gap-delimited serial link. Buffers bytes from a local producer until a packet is committed, then serialises them back-to-back 8N1 on uart_tx_pin. After every packet it holds the line idle for a guaranteed gap, so the far-end receiver's quiet-period detector (one byte period) always sees a packet boundary.

Parameters:
CLOCK_FREQUENCY, 27000000, system clock in Hz
BAUD_RATE, 115200, line rate; BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE (truncating integer divide)
DEPTH, 32, packet buffer depth in bytes (power of 2, >= 2)
GAP_BYTES, 2, post-packet idle time in byte periods (>= 2); one byte period = 10 * BAUD_DIVISOR clocks

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
byte_in  input  8  data byte to append to packet
byte_valid  input  1  append byte_in this cycle when byte_ready=1
packet_end  input  1  commit packet; byte_in on the same cycle (if byte_valid) is the last byte
byte_ready  output  1  buffer accepting bytes (state LOAD and not full)
byte_count  output  $clog2(DEPTH)+1  bytes currently in buffer
overflow  output  1  one-cycle pulse: byte_valid while not accepted
uart_tx_pin  output  1  serial output, idle high
busy  output  1  high in SEND and GAP
packet_sent  output  1  one-cycle pulse at end of GAP

Behaviour:
- Reset values: uart_tx_pin=1, busy=0, packet_sent=0, overflow=0, byte_count=0, byte_ready=1, state=LOAD, baud/bit counters 0. Reset mid-SEND or mid-GAP: pin high on the next edge, buffer discarded, no packet_sent.
- States: LOAD -> SEND -> GAP -> LOAD.
- LOAD: byte_valid && byte_ready writes byte_in at the write pointer, byte_count+1. packet_end with byte_count (after any same-cycle write) >= 1 -> SEND. packet_end with zero bytes and no byte_valid is ignored: stay LOAD, no gap, no pulse.
- byte_valid when full (byte_count=DEPTH) or outside LOAD: byte dropped, overflow pulses next cycle. packet_end outside LOAD ignored. packet_end with byte_valid while full: byte dropped, overflow pulses, commit still occurs.
- SEND: uart_tx_pin registered. Start bit (0) driven from the first edge after the commit edge. Frame: start 0, data bits LSB first, stop 1; every bit exactly BAUD_DIVISOR clocks. Next byte's start bit follows the previous stop bit with zero idle clocks. byte_ready=0 throughout SEND and GAP.
- After the last stop bit's BAUD_DIVISOR clocks -> GAP. GAP holds the pin high for GAP_BYTES*10*BAUD_DIVISOR clocks. Then packet_sent pulses for one cycle, byte_count=0, pointers cleared, state -> LOAD, byte_ready=1 on that same cycle.
- Counters wide enough for GAP_BYTES*10*BAUD_DIVISOR without wrap; buffer pointers wrap modulo DEPTH.
- Packet duration = N*10*BAUD_DIVISOR line clocks plus the gap.

Optional Feature:
UART_PKT_CHECKSUM_EN. Defined: a running 8-bit sum of all accepted bytes (mod 256) is kept. After the last data byte, one extra frame carrying (0 - sum) mod 256 is sent, so the sum of all transmitted bytes = 0x00. The gap follows the checksum frame. The sum clears on reset and on packet_sent. The checksum frame does not use a buffer slot. Undefined: no sum logic; the gap follows the last data byte.

Test Plan (CLOCK_FREQUENCY=1000000, BAUD_RATE=100000 -> BAUD_DIVISOR=10, GAP_BYTES=2):
- Write 0xA5 with packet_end on the same cycle -> pin low for 10 clocks from the next edge, then bits 1,0,1,0,0,1,0,1 at 10 clocks each, stop high. High for 200 more clocks. packet_sent pulses at clock 300 after commit. byte_ready returns to 1.
- Write 0x01, 0x02, 0x03, then packet_end -> three frames, no idle between stop and next start. packet_sent at 300+200 clocks. busy high throughout.
- Write 32 bytes, then a 33rd byte_valid -> overflow pulses once, byte_count stays 32. Commit -> exactly 32 frames.
- packet_end with empty buffer -> pin stays high, no packet_sent, byte_ready stays 1. byte_valid during SEND -> overflow pulse, that byte never transmitted.
- Assert reset at bit 4 of the second frame -> pin high the next cycle. busy=0, byte_count=0, no packet_sent. A fresh packet afterwards transmits correctly.
- UART_PKT_CHECKSUM_EN: send 0x10, 0x20 -> third frame 0xD0. Gap begins after the 0xD0 stop bit.
